// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_stage
//  Purpose  : IF/ID pipeline stage with imem handshake, 1-entry skid, flush.
//             Optional perf counters enabled by the macro IF_ID_PERF_EN.
//  Revision : 1.0  initial release
// ============================================================================
module if_id_stage (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        pc_hold,
  output logic [31:0] pc_hold_val,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      r_state, w_next_state;
  logic [31:0] r_req_addr;
  logic [31:0] r_skid_pc, r_skid_instr;
  logic        w_load_resp, w_load_skid, w_store_skid;
  logic        w_bubble, w_clear_id, w_capture;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_state <= RUN;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b1;
    imem_addr    = r_req_addr;
    pc_hold      = 1'b0;
    w_load_resp  = 1'b0;
    w_load_skid  = 1'b0;
    w_store_skid = 1'b0;
    w_bubble     = 1'b0;
    w_clear_id   = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      RUN, WAIT: begin
        if (r_state == RUN) imem_addr = pc_in;
        pc_hold = ~imem_ready;
        if (imem_ready) begin
          if (stall) begin
            w_store_skid = 1'b1;
            w_next_state = HOLD;
          end else begin
            w_load_resp  = 1'b1;
            w_next_state = RUN;
          end
        end else begin
          // No instruction for ID this cycle: a non-stalled ID consumes a bubble
          w_capture    = (r_state == RUN);
          w_bubble     = ~stall;
          w_next_state = WAIT;
        end
      end
      HOLD: begin
        imem_req  = 1'b0;
        imem_addr = pc_in;
        pc_hold   = 1'b1;
        if (!stall) begin
          w_load_skid  = 1'b1;
          w_next_state = RUN;
        end
      end
      DROP: begin
        pc_hold = 1'b1;
        if (imem_ready) w_next_state = RUN;
      end
    endcase

    if (flush) begin
      pc_hold      = 1'b0;
      w_clear_id   = 1'b1;
      w_load_resp  = 1'b0;
      w_load_skid  = 1'b0;
      w_store_skid = 1'b0;
      w_bubble     = 1'b0;
      w_capture    = (r_state == RUN) && !imem_ready;
      if (r_state == HOLD || imem_ready) w_next_state = RUN;
      else                               w_next_state = DROP;
    end
  end

  assign pc_hold_val = imem_addr;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_req_addr   <= 32'h0;
      r_skid_pc    <= 32'h0;
      r_skid_instr <= 32'h0;
      id_valid     <= 1'b0;
      id_pc        <= 32'h0;
      id_instr     <= 32'h0;
      id_pc_plus4  <= 32'h0;
    end else begin
      if (w_capture) r_req_addr <= pc_in;

      if (w_store_skid) begin
        r_skid_pc    <= imem_addr;
        r_skid_instr <= imem_rdata;
      end else if (w_clear_id) begin
        r_skid_pc    <= 32'h0;
        r_skid_instr <= 32'h0;
      end

      if (w_clear_id) begin
        id_valid    <= 1'b0;
        id_pc       <= 32'h0;
        id_instr    <= 32'h0;
        id_pc_plus4 <= 32'h0;
      end else if (w_load_resp) begin
        id_valid    <= 1'b1;
        id_pc       <= imem_addr;
        id_instr    <= imem_rdata;
        id_pc_plus4 <= imem_addr + 32'd4;
      end else if (w_load_skid) begin
        id_valid    <= 1'b1;
        id_pc       <= r_skid_pc;
        id_instr    <= r_skid_instr;
        id_pc_plus4 <= r_skid_pc + 32'd4;
      end else if (w_bubble) begin
        id_valid    <= 1'b0;
      end
    end
  end

`ifdef IF_ID_PERF_EN
  logic [31:0] r_fetch_cnt, r_bubble_cnt;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_fetch_cnt  <= 32'h0;
      r_bubble_cnt <= 32'h0;
    end else begin
      if (w_load_resp || w_load_skid) r_fetch_cnt  <= r_fetch_cnt + 32'd1;
      if (!id_valid)                  r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt  = r_fetch_cnt;
  assign perf_bubble_cnt = r_bubble_cnt;
`else
  assign perf_fetch_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_stage
//  Purpose  : Self-checking bench for if_id_stage (directed + random traffic).
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_id_stage;

  logic        CLK = 1'b0;
  logic        Reset, stall, flush, imem_ready;
  logic [31:0] pc_in, imem_rdata;
  logic        imem_req, pc_hold, id_valid;
  logic [31:0] imem_addr, pc_hold_val, id_pc, id_instr, id_pc_plus4;
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;

  int errors = 0;
  int checks = 0;

  if_id_stage dut (
    .CLK(CLK), .Reset(Reset), .pc_in(pc_in), .stall(stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc_hold(pc_hold), .pc_hold_val(pc_hold_val),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .perf_fetch_cnt(perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference model: outstanding-request bookkeeping plus a skid queue
  logic        m_valid;
  logic [31:0] m_pc, m_instr;
  bit          m_pending, m_drop;
  logic [31:0] m_addr;
  logic [31:0] skid_pc[$];
  logic [31:0] skid_instr[$];
  bit   [31:0] m_fetch, m_bubble;
  logic        e_req, e_hold;
  logic [31:0] e_addr;

  function automatic void model_reset();
    m_valid = 1'b0; m_pc = 0; m_instr = 0;
    m_pending = 0; m_drop = 0; m_addr = 0;
    skid_pc.delete(); skid_instr.delete();
    m_fetch = 0; m_bubble = 0;
  endfunction

  function automatic void model_comb();
    if (skid_pc.size() != 0) begin
      e_req = 1'b0; e_addr = pc_in; e_hold = !flush;
    end else if (m_drop) begin
      e_req = 1'b1; e_addr = m_addr; e_hold = !flush;
    end else begin
      e_req = 1'b1; e_addr = m_pending ? m_addr : pc_in;
      e_hold = !flush && !imem_ready;
    end
  endfunction

  function automatic void model_edge();
    bit holding;
    model_comb();
    holding = (skid_pc.size() != 0);
    if (!m_valid) m_bubble++;
    if (flush) begin
      m_valid = 1'b0; m_pc = 0; m_instr = 0;
      skid_pc.delete(); skid_instr.delete();
      m_pending = 0;
      if (holding || imem_ready) m_drop = 0;
      else begin m_drop = 1; m_addr = e_addr; end
    end else if (holding) begin
      if (!stall) begin
        m_valid = 1'b1; m_pc = skid_pc.pop_front(); m_instr = skid_instr.pop_front();
        m_fetch++;
      end
    end else if (m_drop) begin
      if (imem_ready) m_drop = 0;
    end else if (imem_ready) begin
      m_pending = 0;
      if (stall) begin
        skid_pc.push_back(e_addr); skid_instr.push_back(imem_rdata);
      end else begin
        m_valid = 1'b1; m_pc = e_addr; m_instr = imem_rdata; m_fetch++;
      end
    end else begin
      m_pending = 1; m_addr = e_addr;
      if (!stall) m_valid = 1'b0;
    end
  endfunction

  task automatic drive(input logic [31:0] pc, input logic st, input logic fl,
                       input logic rdy, input logic [31:0] rd);
    pc_in = pc; stall = st; flush = fl; imem_ready = rdy; imem_rdata = rd;
    #1;
    model_comb();
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    model_reset();
    drive(32'h40, 0, 0, 0, 32'h0);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", id_instr); end
    checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_plus4: got %h expected 0", id_pc_plus4); end
    checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b/%h expected 1/00000040", imem_req, imem_addr); end
    checks++; if (perf_fetch_cnt !== 32'h0 || perf_bubble_cnt !== 32'h0) begin errors++; $display("FAIL reset_perf: got %h/%h expected 0/0", perf_fetch_cnt, perf_bubble_cnt); end
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    drive(32'h0, 0, 0, 1, 32'h2008_0005);
    checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL basic_pc_hold: got %b expected 0", pc_hold); end
    tick();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", id_valid); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL basic_pc: got %h expected 0", id_pc); end
    checks++; if (id_instr !== 32'h2008_0005) begin errors++; $display("FAIL basic_instr: got %h expected 20080005", id_instr); end
    checks++; if (id_pc_plus4 !== 32'h4) begin errors++; $display("FAIL basic_plus4: got %h expected 4", id_pc_plus4); end
  endtask

  task automatic test_wait();
    for (int i = 0; i < 3; i++) begin
      drive(32'h8, 0, 0, 0, 32'hDEAD_BEEF);
      checks++; if (pc_hold !== 1'b1 || pc_hold_val !== 32'h8) begin errors++; $display("FAIL wait_hold[%0d]: got %b/%h expected 1/00000008", i, pc_hold, pc_hold_val); end
      tick();
      checks++; if (id_valid !== m_valid) begin errors++; $display("FAIL wait_valid[%0d]: got %b expected %b", i, id_valid, m_valid); end
    end
    drive(32'h8, 0, 0, 1, 32'hAC01_0000);
    checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL wait_ready_hold: got %b expected 0", pc_hold); end
    tick();
    checks++; if (id_pc !== 32'h8 || id_instr !== 32'hAC01_0000) begin errors++; $display("FAIL wait_id: got %h/%h expected 00000008/ac010000", id_pc, id_instr); end
  endtask

  task automatic test_stall();
    drive(32'hC, 1, 0, 1, 32'h1111_2222);
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b expected 0", imem_req); end
    checks++; if (id_pc !== 32'h8) begin errors++; $display("FAIL stall_id_hold: got %h expected 00000008", id_pc); end
    drive(32'h10, 1, 0, 1, 32'h3333_4444);
    tick();
    checks++; if (id_pc !== 32'h8 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_ignore_ready: got %h/%b expected 00000008/0", id_pc, imem_req); end
    drive(32'h10, 0, 0, 0, 32'h0);
    checks++; if (pc_hold !== 1'b1 || pc_hold_val !== 32'h10) begin errors++; $display("FAIL stall_pc_hold: got %b/%h expected 1/00000010", pc_hold, pc_hold_val); end
    tick();
    checks++; if (id_pc !== 32'hC || id_instr !== 32'h1111_2222 || id_pc_plus4 !== 32'h10) begin errors++; $display("FAIL stall_release: got %h/%h/%h expected 0000000c/11112222/00000010", id_pc, id_instr, id_pc_plus4); end
  endtask

  task automatic test_flush();
    drive(32'h10, 0, 0, 0, 32'h0);
    tick();
    drive(32'h20, 0, 1, 0, 32'h0);
    checks++; if (pc_hold !== 1'b0 || imem_addr !== 32'h10) begin errors++; $display("FAIL flush_comb: got %b/%h expected 0/00000010", pc_hold, imem_addr); end
    tick();
    checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0) begin errors++; $display("FAIL flush_id: got %b/%h/%h expected 0/0/0", id_valid, id_instr, id_pc); end
    drive(32'h28, 0, 0, 1, 32'hFFFF_FFFF);
    checks++; if (pc_hold !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL flush_drop_comb: got %b/%h expected 1/00000010", pc_hold, imem_addr); end
    tick();
    checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin errors++; $display("FAIL flush_discard: got %b/%h expected 0/0", id_valid, id_instr); end
    drive(32'h28, 0, 0, 1, 32'h0123_4567);
    checks++; if (imem_addr !== 32'h28) begin errors++; $display("FAIL flush_run_addr: got %h expected 00000028", imem_addr); end
    tick();
    checks++; if (id_pc !== 32'h28 || id_instr !== 32'h0123_4567) begin errors++; $display("FAIL flush_resume: got %h/%h expected 00000028/01234567", id_pc, id_instr); end
  endtask

  task automatic test_wrap_and_reset();
    drive(32'hFFFF_FFFC, 0, 0, 1, 32'h5555_AAAA);
    tick();
    checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h/%h expected fffffffc/0", id_pc, id_pc_plus4); end
    drive(32'h64, 0, 0, 0, 32'h0);
    tick();
    drive(32'hC8, 0, 0, 0, 32'h0);
    #1 Reset = 1'b1;
    #1;
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0 || id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL async_reset_id: got %b/%h/%h/%h expected all 0", id_valid, id_pc, id_instr, id_pc_plus4); end
    checks++; if (imem_addr !== 32'hC8) begin errors++; $display("FAIL async_reset_addr: got %h expected 000000c8", imem_addr); end
    @(negedge CLK);
    Reset = 1'b0;
    model_reset();
    drive(32'hC8, 0, 0, 1, 32'h7777_0001);
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'hC8) begin errors++; $display("FAIL reset_first_resp: got %b/%h expected 1/000000c8", id_valid, id_pc); end
  endtask

  task automatic test_perf();
    logic [2:0] seq [7];
    seq = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 7; i++) begin
      drive(32'h100 + 32'(i * 4), 0, seq[i][0], 1, $urandom);
      tick();
    end
`ifdef IF_ID_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'd5) begin errors++; $display("FAIL perf_fetch: got %0d expected 5", perf_fetch_cnt); end
    checks++; if (perf_bubble_cnt !== m_bubble) begin errors++; $display("FAIL perf_bubble: got %0d expected %0d", perf_bubble_cnt, m_bubble); end
`else
    checks++; if (perf_fetch_cnt !== 32'd0 || perf_bubble_cnt !== 32'd0) begin errors++; $display("FAIL perf_off: got %0d/%0d expected 0/0", perf_fetch_cnt, perf_bubble_cnt); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6), $urandom);
      checks++; if (imem_req !== e_req || imem_addr !== e_addr) begin errors++; $display("FAIL rand_req[%0d]: got %b/%h expected %b/%h", i, imem_req, imem_addr, e_req, e_addr); end
      checks++; if (pc_hold !== e_hold || pc_hold_val !== e_addr) begin errors++; $display("FAIL rand_hold[%0d]: got %b/%h expected %b/%h", i, pc_hold, pc_hold_val, e_hold, e_addr); end
      tick();
      checks++; if (id_valid !== m_valid || id_pc !== m_pc || id_instr !== m_instr) begin errors++; $display("FAIL rand_id[%0d]: got %b/%h/%h expected %b/%h/%h", i, id_valid, id_pc, id_instr, m_valid, m_pc, m_instr); end
      checks++; if (id_pc_plus4 !== m_pc + 32'd4 && !(m_pc == 0 && m_instr == 0 && !m_valid && id_pc_plus4 === 32'h0)) begin errors++; $display("FAIL rand_plus4[%0d]: got %h expected %h", i, id_pc_plus4, m_pc + 32'd4); end
`ifdef IF_ID_PERF_EN
      checks++; if (perf_fetch_cnt !== m_fetch || perf_bubble_cnt !== m_bubble) begin errors++; $display("FAIL rand_perf[%0d]: got %0d/%0d expected %0d/%0d", i, perf_fetch_cnt, perf_bubble_cnt, m_fetch, m_bubble); end
`endif
    end
  endtask

  initial begin
    Reset = 1'b1; stall = 0; flush = 0; imem_ready = 0; pc_in = 0; imem_rdata = 0;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_wait();
    test_stall();
    test_flush();
    test_wrap_and_reset();
    test_perf();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have ports: CLK  in  1  clock, rising edge; Reset  in  1  asynchronous, active-high reset.
REQ-002 SHALL have: pc_in  in  32  current fetch address from PC register; stall  in  1  hazard hold of ID stage; flush  in  1  taken branch/jump, kill fetched instruction.
REQ-003 SHALL have: imem_req  out  1  fetch request; imem_addr  out  32  fetch address; imem_ready  in  1  response valid this cycle; imem_rdata  in  32  instruction word.
REQ-004 SHALL have: pc_hold  out  1  drives PC PCdelay; pc_hold_val  out  32  drives PC prePC.
REQ-005 SHALL have: id_valid  out  1; id_pc  out  32; id_instr  out  32; id_pc_plus4  out  32 (all registered).
REQ-006 SHALL have: perf_fetch_cnt  out  32; perf_bubble_cnt  out  32 (see Configuration).

Function
REQ-007 SHALL implement FSM states RUN, WAIT, HOLD, DROP; priority Reset > flush > stall > normal.
REQ-008 RUN: imem_req=1, imem_addr=pc_in; WAIT/DROP: imem_req=1, imem_addr=req_addr (captured register); HOLD: imem_req=0.
REQ-009 pc_hold_val SHALL equal imem_addr (RUN/WAIT/DROP) or pc_in (HOLD).
REQ-010 pc_hold SHALL be 1 in RUN/WAIT when imem_ready=0, 1 in HOLD and DROP, else 0; pc_hold SHALL be forced 0 whenever flush=1.
REQ-011 RUN/WAIT, imem_ready=1, stall=0, flush=0: at edge ID <= {valid=1, pc=imem_addr, instr=imem_rdata, pc_plus4=imem_addr+4}; next RUN; latency from accepted response to id_valid is 1 cycle.
REQ-012 RUN/WAIT, imem_ready=1, stall=1, flush=0: response SHALL be stored in 1-entry skid {pc, instr}; ID holds; next HOLD.
REQ-013 RUN, imem_ready=0, flush=0: req_addr <= pc_in; next WAIT. WAIT, imem_ready=0: stay WAIT.
REQ-014 HOLD, stall=0: ID <= skid contents (valid=1); next RUN. HOLD, stall=1: hold all.
REQ-015 stall=1 with no response: ID registers SHALL hold unchanged.
REQ-016 flush=1 at edge: id_valid<=0, id_instr<=32'h0000_0000 (NOP), id_pc/id_pc_plus4<=0; skid discarded; response arriving that cycle discarded.
REQ-017 flush next state: RUN->RUN if imem_ready=1, else DROP (req_addr<=pc_in); WAIT->RUN if imem_ready=1, else DROP; HOLD->RUN; DROP->DROP unless imem_ready=1 (->RUN).
REQ-018 DROP, imem_ready=1: response SHALL be discarded, ID unchanged, next RUN.
REQ-019 id_pc_plus4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-020 imem_ready outside a request (HOLD) SHALL be ignored.

Reset
REQ-021 Reset=1 SHALL asynchronously force state RUN, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, req_addr=0, skid cleared, counters 0.
REQ-022 Reset mid-WAIT/DROP SHALL abandon outstanding request; the first response after release is accepted as a RUN response.

Configuration
REQ-023 Macro IF_ID_PERF_EN defined: perf_fetch_cnt increments per instruction written to ID with valid=1; perf_bubble_cnt increments each cycle id_valid=0 after reset release; both wrap at 2^32.
REQ-024 IF_ID_PERF_EN undefined: counters not built; both perf ports SHALL be constant 0.

Verification
REQ-025 Reset, pc_in=0, imem_ready=1, rdata=32'h2008_0005 -> after 1 edge id_valid=1, id_pc=0, id_instr=32'h2008_0005, id_pc_plus4=4, pc_hold=0.
REQ-026 pc_in=8, imem_ready=0 for 3 cycles then 1 with rdata=32'hAC01_0000 -> pc_hold=1, pc_hold_val=8 during wait; id_pc=8 one edge after ready.
REQ-027 stall=1 while response pc=12 arrives -> state HOLD, imem_req=0, ID unchanged; stall=0 -> next edge id_pc=12.
REQ-028 WAIT at pc=16, flush=1, imem_ready=0, then ready with rdata=32'hFFFF_FFFF -> pc_hold=0 during flush cycle, id_valid=0, id_instr=0, response discarded, RUN after.
REQ-029 pc_in=32'hFFFF_FFFC accepted -> id_pc_plus4=0; Reset asserted in WAIT -> all ID outputs 0 immediately.
REQ-030 With IF_ID_PERF_EN, 5 accepted fetches and 2 flushes -> perf_fetch_cnt=5; without macro both counters read 0.
